// File: rtl/mem_access_io_arbiter_stage.sv
// rtl/mem_access_io_arbiter_stage.sv - memory access stage with round-robin IO load arbiter
module mem_access_io_arbiter_stage #(
  parameter int LANES    = 2,
  parameter int DATA_W   = 32,
  parameter int AL_PTR_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall_in,
  input  logic                       clear_in,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES-1:0]           in_is_load,
  input  logic [LANES-1:0]           in_is_io,
  input  logic [LANES-1:0]           in_is_csr,
  input  logic [LANES*DATA_W-1:0]    in_addr,
  input  logic [LANES*DATA_W-1:0]    in_csr_data,
  input  logic [LANES*AL_PTR_W-1:0]  in_al_ptr,
  input  logic [LANES*DATA_W-1:0]    ld_data,
  input  logic                       flush_valid,
  input  logic                       flush_all,
  input  logic [AL_PTR_W-1:0]        flush_head,
  input  logic [AL_PTR_W-1:0]        flush_tail,
  output logic                       io_req,
  output logic [DATA_W-1:0]          io_addr,
  input  logic                       io_ack,
  input  logic [DATA_W-1:0]          io_rdata,
  output logic                       stall_req,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES*DATA_W-1:0]    out_data,
  output logic [LANES*AL_PTR_W-1:0]  out_al_ptr
);

  localparam int RR_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [RR_W-1:0]       rr_q, rr_d, grant_q, grant_d;
  logic [LANES-1:0]      valid_q, done_q, load_q, io_q, csr_q;
  logic [DATA_W-1:0]     addr_q    [LANES];
  logic [DATA_W-1:0]     csr_data_q[LANES];
  logic [DATA_W-1:0]     io_data_q [LANES];
  logic [AL_PTR_W-1:0]   ptr_q     [LANES];
  logic [LANES-1:0]      flushed, need_io;
  logic                  capture, io_take;

  // Active-list range test; head==tail is an empty range.
  function automatic logic in_range(input logic [AL_PTR_W-1:0] p,
                                    input logic [AL_PTR_W-1:0] h,
                                    input logic [AL_PTR_W-1:0] t);
    if (h < t)      return (p >= h) && (p < t);
    else if (h > t) return (p >= h) || (p < t);
    else            return 1'b0;
  endfunction

  // Per-lane flush hits, outstanding IO work, stall request and capture enable.
  always_comb begin
    flushed = '0;
    need_io = '0;
    for (int i = 0; i < LANES; i++) begin
      flushed[i] = flush_valid && (flush_all || in_range(ptr_q[i], flush_head, flush_tail));
      need_io[i] = valid_q[i] && load_q[i] && io_q[i] && !done_q[i] && !flushed[i];
    end
    stall_req = (|need_io) || (state_q != IDLE);
    capture   = !stall_in && !stall_req && !clear_in;
  end

  // IO arbiter FSM: round-robin grant, wait for ack, or drain a flushed request.
  always_comb begin
    int   idx;
    logic found;
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    io_req  = 1'b0;
    io_take = 1'b0;
    idx     = 0;
    found   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!clear_in) begin
          for (int j = 0; j < LANES; j++) begin
            idx = (int'(rr_q) + j) % LANES;
            if (!found && need_io[idx]) begin
              found   = 1'b1;
              grant_d = RR_W'(idx);
              rr_d    = RR_W'((idx + 1) % LANES);
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        io_req = 1'b1;
        if (flushed[grant_q] || !valid_q[grant_q] || clear_in) begin
          state_d = io_ack ? IDLE : DRAIN;
        end else if (io_ack) begin
          io_take = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        io_req = 1'b1;
        if (io_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign io_addr = addr_q[grant_q];

  // FSM, round-robin pointer and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  // Lane valid, done flags and captured IO data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      for (int i = 0; i < LANES; i++) io_data_q[i] <= '0;
    end else begin
      if (clear_in)     valid_q <= '0;
      else if (capture) valid_q <= in_valid;
      else              valid_q <= valid_q & ~flushed;
      if (capture) done_q <= '0;
      if (io_take) begin
        io_data_q[grant_q] <= io_rdata;
        done_q[grant_q]    <= 1'b1;
      end
    end
  end

  // Lane payload only matters while the lane is valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      load_q <= in_is_load;
      io_q   <= in_is_io;
      csr_q  <= in_is_csr;
      for (int i = 0; i < LANES; i++) begin
        addr_q[i]     <= in_addr[i*DATA_W +: DATA_W];
        csr_data_q[i] <= in_csr_data[i*DATA_W +: DATA_W];
        ptr_q[i]      <= in_al_ptr[i*AL_PTR_W +: AL_PTR_W];
      end
    end
  end

  // Writeback: whole group releases together once no IO work remains.
  always_comb begin
    out_valid  = '0;
    out_data   = '0;
    out_al_ptr = '0;
    for (int i = 0; i < LANES; i++) begin
      out_valid[i] = valid_q[i] && !stall_req && !stall_in && !clear_in && !flushed[i];
      if (load_q[i] && io_q[i])  out_data[i*DATA_W +: DATA_W] = io_data_q[i];
      else if (load_q[i])        out_data[i*DATA_W +: DATA_W] = ld_data[i*DATA_W +: DATA_W];
      else if (csr_q[i])         out_data[i*DATA_W +: DATA_W] = csr_data_q[i];
      else                       out_data[i*DATA_W +: DATA_W] = addr_q[i];
      out_al_ptr[i*AL_PTR_W +: AL_PTR_W] = ptr_q[i];
    end
  end

endmodule

// File: tb/tb_mem_access_io_arbiter_stage.sv
// tb/tb_mem_access_io_arbiter_stage.sv - scoreboard bench for mem_access_io_arbiter_stage
module tb_mem_access_io_arbiter_stage;
  localparam int LANES = 2;
  localparam int DW    = 32;
  localparam int PW    = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall_in, clear_in;
  logic [LANES-1:0]  in_valid, in_is_load, in_is_io, in_is_csr;
  logic [LANES*DW-1:0] in_addr, in_csr_data, ld_data, out_data;
  logic [LANES*PW-1:0] in_al_ptr, out_al_ptr;
  logic              flush_valid, flush_all;
  logic [PW-1:0]     flush_head, flush_tail;
  logic              io_req, io_ack, stall_req;
  logic [DW-1:0]     io_addr, io_rdata;
  logic [LANES-1:0]  out_valid;

  typedef struct {int lane; logic [DW-1:0] data; logic [PW-1:0] ptr;} exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  mem_access_io_arbiter_stage #(.LANES(LANES), .DATA_W(DW), .AL_PTR_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .clear_in(clear_in),
    .in_valid(in_valid), .in_is_load(in_is_load), .in_is_io(in_is_io), .in_is_csr(in_is_csr),
    .in_addr(in_addr), .in_csr_data(in_csr_data), .in_al_ptr(in_al_ptr), .ld_data(ld_data),
    .flush_valid(flush_valid), .flush_all(flush_all), .flush_head(flush_head), .flush_tail(flush_tail),
    .io_req(io_req), .io_addr(io_addr), .io_ack(io_ack), .io_rdata(io_rdata),
    .stall_req(stall_req), .out_valid(out_valid), .out_data(out_data), .out_al_ptr(out_al_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every released lane must match the oldest expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        if (out_valid[i]) begin
          check("sb_expected_output", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_lane", 64'(i), 64'(e.lane));
            check("sb_data", 64'(out_data[i*DW +: DW]), 64'(e.data));
            check("sb_alptr", 64'(out_al_ptr[i*PW +: PW]), 64'(e.ptr));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input int lane, input logic [DW-1:0] d, input logic [PW-1:0] p);
    exp_t e;
    e.lane = lane; e.data = d; e.ptr = p;
    sb.push_back(e);
  endtask

  task automatic set_lane(input int i, input logic ld, input logic io, input logic csr,
                          input logic [DW-1:0] a, input logic [DW-1:0] cd, input logic [PW-1:0] p);
    in_valid[i]   = 1'b1;
    in_is_load[i] = ld;
    in_is_io[i]   = io;
    in_is_csr[i]  = csr;
    in_addr[i*DW +: DW]     = a;
    in_csr_data[i*DW +: DW] = cd;
    in_al_ptr[i*PW +: PW]   = p;
  endtask

  task automatic idle_lanes();
    in_valid = '0; in_is_load = '0; in_is_io = '0; in_is_csr = '0;
  endtask

  task automatic wait_io();
    int n = 0;
    @(negedge clk);
    while (!io_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("io_req_timeout", 64'(io_req), 64'd1);
  endtask

  task automatic serve(input logic [DW-1:0] exp_addr, input logic [DW-1:0] d);
    wait_io();
    check("io_addr", 64'(io_addr), 64'(exp_addr));
    check("io_stall", 64'(stall_req), 64'd1);
    repeat (2) begin
      @(negedge clk);
      check("io_addr_stable", 64'(io_addr), 64'(exp_addr));
      check("io_wait_no_out", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    io_ack = 1'b1; io_rdata = d;
    @(posedge clk); #1;
    io_ack = 1'b0; io_rdata = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall_in = 1'b0; clear_in = 1'b0;
    idle_lanes();
    in_addr = '0; in_csr_data = '0; in_al_ptr = '0;
    ld_data = {32'h0000_BEEF, 32'h0000_DEAD};
    flush_valid = 1'b0; flush_all = 1'b0; flush_head = '0; flush_tail = '0;
    io_ack = 1'b0; io_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_io_req", 64'(io_req), 64'd0);
    check("rst_stall_req", 64'(stall_req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Plain cache load on lane 0.
    set_lane(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 6'd1);
    push(0, 32'hDEAD, 6'd1);
    tick(); idle_lanes();
    @(negedge clk);
    check("ld_out_valid", 64'(out_valid), 64'b01);
    check("ld_stall_req", 64'(stall_req), 64'd0);
    tick();

    // CSR on lane 0, cache load on lane 1.
    set_lane(0, 1'b0, 1'b0, 1'b1, 32'h111, 32'hC5, 6'd2);
    set_lane(1, 1'b1, 1'b0, 1'b0, 32'h222, 32'hEE, 6'd3);
    push(0, 32'hC5, 6'd2);
    push(1, 32'hBEEF, 6'd3);
    tick(); idle_lanes();
    @(negedge clk);
    check("csr_out_valid", 64'(out_valid), 64'b11);
    tick();

    // Two IO loads served in lane order.
    set_lane(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 6'd2);
    set_lane(1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 6'd3);
    push(0, 32'h11, 6'd2);
    push(1, 32'h22, 6'd3);
    tick(); idle_lanes();
    @(negedge clk);
    check("io2_stall_start", 64'(stall_req), 64'd1);
    check("io2_no_out", 64'(out_valid), 64'd0);
    serve(32'h40, 32'h11);
    @(negedge clk);
    check("io2_stall_between", 64'(stall_req), 64'd1);
    serve(32'h44, 32'h22);
    @(negedge clk);
    check("io2_stall_drop", 64'(stall_req), 64'd0);
    check("io2_out_valid", 64'(out_valid), 64'b11);
    tick();

    // IO load flushed during WAIT by a wrapping range, then drained.
    set_lane(0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 6'd4);
    set_lane(1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 6'd6);
    push(0, 32'h300, 6'd4);
    tick(); idle_lanes();
    wait_io();
    check("drain_io_addr", 64'(io_addr), 64'h50);
    flush_valid = 1'b1; flush_head = 6'd5; flush_tail = 6'd3;
    #1;
    check("drain_flush_no_out", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    flush_valid = 1'b0;
    @(negedge clk);
    check("drain_io_req", 64'(io_req), 64'd1);
    check("drain_stall", 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    io_ack = 1'b1; io_rdata = 32'h99;
    @(posedge clk); #1;
    io_ack = 1'b0; io_rdata = '0;
    @(negedge clk);
    check("drain_stall_drop", 64'(stall_req), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'b01);
    tick();

    // Empty flush range keeps the lane; flush_all removes it.
    set_lane(0, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 6'd4);
    push(0, 32'h400, 6'd4);
    tick(); idle_lanes();
    flush_valid = 1'b1; flush_all = 1'b0; flush_head = 6'd4; flush_tail = 6'd4;
    @(negedge clk);
    check("empty_range_kept", 64'(out_valid), 64'b01);
    tick();
    flush_valid = 1'b0;
    set_lane(0, 1'b0, 1'b0, 1'b0, 32'h404, 32'h0, 6'd4);
    tick(); idle_lanes();
    flush_valid = 1'b1; flush_all = 1'b1;
    @(negedge clk);
    check("flush_all_masked", 64'(out_valid), 64'd0);
    tick();
    flush_valid = 1'b0; flush_all = 1'b0;
    @(negedge clk);
    check("flush_all_gone", 64'(out_valid), 64'd0);
    tick();

    // Backend stall holds the group; clear drops it.
    set_lane(0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0, 6'd1);
    push(0, 32'h500, 6'd1);
    tick(); idle_lanes();
    stall_in = 1'b1;
    @(negedge clk);
    check("stall_in_mask", 64'(out_valid), 64'd0);
    tick();
    stall_in = 1'b0;
    @(negedge clk);
    check("stall_in_release", 64'(out_valid), 64'b01);
    tick();
    set_lane(0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 6'd1);
    tick(); idle_lanes();
    clear_in = 1'b1;
    @(negedge clk);
    check("clear_mask", 64'(out_valid), 64'd0);
    tick();
    clear_in = 1'b0;
    @(negedge clk);
    check("clear_gone", 64'(out_valid), 64'd0);
    tick();

    // Lane 1 granted, then round-robin wraps to lane 0 for the next group.
    set_lane(1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 6'd7);
    push(1, 32'h55, 6'd7);
    tick(); idle_lanes();
    serve(32'h80, 32'h55);
    @(negedge clk);
    check("rrA_out_valid", 64'(out_valid), 64'b10);
    tick();
    set_lane(0, 1'b1, 1'b1, 1'b0, 32'h90, 32'h0, 6'd8);
    set_lane(1, 1'b1, 1'b1, 1'b0, 32'h94, 32'h0, 6'd9);
    push(0, 32'h66, 6'd8);
    push(1, 32'h77, 6'd9);
    tick(); idle_lanes();
    serve(32'h90, 32'h66);
    serve(32'h94, 32'h77);
    @(negedge clk);
    check("rrB_out_valid", 64'(out_valid), 64'b11);
    tick();

    // Reset during WAIT abandons the request; late ack is ignored.
    set_lane(1, 1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 6'd10);
    tick(); idle_lanes();
    wait_io();
    #1;
    rst_n = 1'b0;
    #1;
    check("rstw_io_req", 64'(io_req), 64'd0);
    check("rstw_stall", 64'(stall_req), 64'd0);
    check("rstw_out_valid", 64'(out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    io_ack = 1'b1; io_rdata = 32'hBAD;
    @(negedge clk);
    check("late_ack_io_req", 64'(io_req), 64'd0);
    check("late_ack_stall", 64'(stall_req), 64'd0);
    tick();
    io_ack = 1'b0; io_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      check("late_ack_no_out", 64'(out_valid), 64'd0);
      check("late_ack_idle", 64'(io_req), 64'd0);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_io_arbiter_stage.md
MEM_ACCESS_IO_ARBITER_STAGE -- requirements
Module: mem_access_io_arbiter_stage

Interface
REQ-001 SHALL have parameter LANES, default 2, number of memory issue lanes (1..4).
REQ-002 SHALL have parameter DATA_W, default 32, data/address width.
REQ-003 SHALL have parameter AL_PTR_W, default 6, active-list pointer width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports (name dir width meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  backend stall
- clear_in  in  1  backend clear
- in_valid, in_is_load, in_is_io, in_is_csr  in  LANES each  per-lane op qualifiers
- in_addr, in_csr_data  in  LANES*DATA_W each  address / CSR result
- in_al_ptr  in  LANES*AL_PTR_W  active-list pointer
- ld_data  in  LANES*DATA_W  cache load data for registered ops
- flush_valid, flush_all  in  1 each  recovery flush request / flush everything
- flush_head, flush_tail  in  AL_PTR_W each  flush range [head, tail)
- io_req  out  1  IO read request
- io_addr  out  DATA_W  IO read address
- io_ack  in  1  IO response valid, data on io_rdata
- io_rdata  in  DATA_W  IO read data
- stall_req  out  1  request backend stall while IO outstanding
- out_valid  out  LANES  result valid to writeback
- out_data  out  LANES*DATA_W  result data
- out_al_ptr  out  LANES*AL_PTR_W  registered active-list pointer

Function
REQ-006 SHALL register all lane inputs when !stall_in && !stall_req && !clear_in; hold otherwise.
REQ-007 SHALL clear all lane valid bits on clear_in (synchronous, priority over capture).
REQ-008 SHALL clear a registered lane valid when flush_valid and (flush_all or al_ptr in range); range: head<tail -> head<=p<tail; head>tail (wrap) -> p>=head or p<tail; head==tail -> empty unless flush_all.
REQ-009 SHALL select out_data per lane: IO load -> captured IO data; other load -> ld_data; CSR -> in_csr_data; else in_addr.
REQ-010 SHALL drive out_valid[i] = lane valid && !stall_req && !stall_in && !clear_in && !flushed this cycle; latency 1 cycle from capture for non-IO lanes.
REQ-011 SHALL serialise IO loads from any lane through one IO port, FSM states IDLE, WAIT, DRAIN.
REQ-012 IDLE: if any valid, unflushed, IO load lane not done -> grant one, go WAIT; io_req=0.
REQ-013 WAIT: io_req=1, io_addr=granted lane address held stable until io_ack; on io_ack capture io_rdata into that lane, mark done, go IDLE.
REQ-014 Granted lane flushed in WAIT -> go DRAIN; DRAIN keeps io_req=1 until io_ack, discards data, goes IDLE.
REQ-015 SHALL grant round-robin: pointer rr (reset 0) scans rr, rr+1, ... mod LANES; after grant of lane k, rr=(k+1) mod LANES.
REQ-016 SHALL assert stall_req while any valid unflushed IO load lane is not done, or FSM is WAIT/DRAIN; all lanes of the group release together in the cycle stall_req drops.
REQ-017 Done flags SHALL clear when a new group is captured.
REQ-018 io_ack outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-019 On rst_n=0 SHALL asynchronously clear lane valids, done flags, FSM to IDLE, rr=0, captured IO data to 0; io_req, stall_req, out_valid all 0.
REQ-020 Reset mid-WAIT SHALL abandon the request; a later io_ack SHALL be ignored.

Verification
REQ-021 Lane0 load addr 0x100, ld_data 0xDEAD, no IO -> next cycle out_valid=01, out_data[0]=0xDEAD, stall_req=0.
REQ-022 Both lanes IO loads (0x40, 0x44), io_ack 3 cycles after each req with 0x11/0x22 -> lane0 served first, then lane1; stall_req high throughout; out_valid=11 with 0x11/0x22 the cycle after second ack.
REQ-023 Lane1 IO load in WAIT, flush head=5 tail=3 (wrap), lane1 al_ptr=6 -> DRAIN, response discarded, out_valid[1]=0, stall_req drops after ack.
REQ-024 Flush head=tail=4, flush_all=0, lane al_ptr=4 -> lane not flushed; same with flush_all=1 -> flushed.
REQ-025 Two consecutive groups with IO on lane1 then lane1 again -> rr=0 for second grant (wrap from LANES); rst_n pulsed during WAIT -> io_req=0 immediately, late io_ack ignored.
